// File: rtl/loader_pkg.sv
// Shared types and sizes for the program loader (instruction-memory write path).
package loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  // The header, body words and trailer all go through one packer, sized for the longest field.
  localparam int unsigned PACK_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;
  localparam int unsigned PACK_CNT_W = $clog2(PACK_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BODY,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word packer: collects bytes MSB first and flags the byte that completes a word.
// The completed word is presented combinationally alongside its last byte so the consumer can
// register it on the very edge that accepts that byte.
module word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_complete_c
);

  localparam int unsigned HOLD_W = WORD_W - BYTE_W;

  logic [PACK_CNT_W-1:0] byte_cnt;
  // Only the leading bytes need storage; the final byte is taken straight from the input.
  logic [HOLD_W-1:0]     hold_q;

  // Byte counter and shift register; clear wins over a shift in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      hold_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      hold_q   <= '0;
    end else if (shift_en) begin
      byte_cnt <= byte_cnt + PACK_CNT_W'(1);
      hold_q   <= {hold_q[HOLD_W-BYTE_W-1:0], byte_data};
    end
  end

  assign word_c          = {hold_q, byte_data};
  assign word_complete_c = shift_en && (byte_cnt == PACK_CNT_W'(PACK_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader: turns the host byte stream (count header + big-endian words) into
// instruction-memory writes and holds the core in reset via busy while loading.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a 32-bit sum trailer check.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [WORD_W-1:0] MAX_WORDS = WORD_W'(2 ** ADDR_W);

  state_e            state;
  logic [CNT_W-1:0]  n_words;
  logic [CNT_W-1:0]  next_count;
  logic              accept;
  logic              load_start;
  logic [WORD_W-1:0] pk_word;
  logic              pk_complete;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  assign accept     = byte_valid && byte_ready;
  assign load_start = start && ((state == IDLE) || (state == DONE));
  assign next_count = word_count + CNT_W'(1);

  word_packer u_packer (
    .clk             (clk),
    .rst_n           (rst_n),
    .shift_en        (accept),
    .clear           (load_start),
    .byte_data       (byte_data),
    .word_c          (pk_word),
    .word_complete_c (pk_complete)
  );

  // Load sequencer with registered outputs; byte_ready drops on the edge that takes the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      n_words    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= HEADER;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end

        HEADER: begin
          if (pk_complete) begin
            if (pk_word > MAX_WORDS) begin
              // Oversized program: fail without consuming any body or trailer bytes.
              state      <= DONE;
              error      <= 1'b1;
              busy       <= 1'b0;
              done       <= 1'b1;
              byte_ready <= 1'b0;
            end else if (pk_word == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state      <= CHECK;
`else
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              byte_ready <= 1'b0;
`endif
            end else begin
              state   <= BODY;
              n_words <= CNT_W'(pk_word);
            end
          end
        end

        BODY: begin
          if (pk_complete) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_count[ADDR_W-1:0];
            imem_wdata <= pk_word;
            word_count <= next_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum        <= sum + pk_word;
            if (next_count == n_words) begin
              state <= CHECK;
            end
`else
            if (next_count == n_words) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              byte_ready <= 1'b0;
            end
`endif
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (pk_complete) begin
            state      <= DONE;
            error      <= (pk_word != sum);
            busy       <= 1'b0;
            done       <= 1'b1;
            byte_ready <= 1'b0;
          end
        end
`endif

        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader (built with ADDR_W=4 to reach capacity limits).
module tb_program_loader;

  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  program_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       hdr;
    logic [4:0]        nw;
    logic              gappy;
    logic              start_mid;
    logic              imm_done;
    logic              exp_err;
    logic              exp_err_ck;
    logic [4:0]        exp_wc;
    logic [31:0]       txor;
    logic [15:0][31:0] w;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int passed = 0;
  int total  = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  // Write log, sampled mid-cycle while the strobe is stable.
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else passed++;
  endtask

  function automatic vec_t mk(input logic [31:0] hdr, input int nw, input logic gappy,
                              input logic start_mid, input logic imm_done, input logic exp_err,
                              input logic exp_err_ck, input int exp_wc, input logic [31:0] txor);
    vec_t v;
    v            = '0;
    v.hdr        = hdr;
    v.nw         = 5'(nw);
    v.gappy      = gappy;
    v.start_mid  = start_mid;
    v.imm_done   = imm_done;
    v.exp_err    = exp_err;
    v.exp_err_ck = exp_err_ck;
    v.exp_wc     = 5'(exp_wc);
    v.txor       = txor;
    return v;
  endfunction

  // Called at a negedge; leaves byte_valid high so consecutive calls are back-to-back.
  task automatic send_byte(input logic [7:0] b, input logic gap, input logic pulse_start);
    int t = 0;
    while (!byte_ready && t < 50) begin
      byte_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("ready_timeout", 64'(byte_ready), 64'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    start      = pulse_start;
    @(negedge clk);
    start = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic gap, input logic pulse_start);
    logic [31:0] tmp;
    tmp = w;
    for (int b = 0; b < 4; b++) begin
      send_byte(tmp[31:24], gap, pulse_start && (b == 1));
      tmp = tmp << 8;
    end
  endtask

  task automatic pulse_start_task();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] sum;
    logic        exp_err;
    string       tag;

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    vecs[0] = mk(32'd2,  2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2,  32'd0);
    vecs[0].w[0] = 32'h0C220005;
    vecs[0].w[1] = 32'h24000010;
    vecs[1] = mk(32'd0,  0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,  32'd0);
    vecs[2] = mk(32'd17, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0,  32'd0);
    vecs[3] = mk(32'd3,  3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3,  32'd0);
    vecs[3].w[0] = 32'h11223344;
    vecs[3].w[1] = 32'h55667788;
    vecs[3].w[2] = 32'h99AABBCC;
    vecs[4] = vecs[3];
    vecs[4].gappy     = 1'b0;
    vecs[4].start_mid = 1'b0;
    vecs[5] = mk(32'd16, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 32'd0);
    for (int i = 0; i < 16; i++) vecs[5].w[i] = 32'hA5000000 + 32'(i);
    vecs[6] = mk(32'd2,  2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2,  32'd0);
    vecs[6].w[0] = 32'h00000001;
    vecs[6].w[1] = 32'hFFFFFFFF;
    vecs[7] = mk(32'd2,  2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2,  32'd1);
    vecs[7].w[0] = 32'h00000001;
    vecs[7].w[1] = 32'hFFFFFFFF;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_done",       64'(done),       64'd0);
    chk("rst_error",      64'(error),      64'd0);
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_imem_we",    64'(imem_we),    64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NVEC; k++) begin
      v   = vecs[k];
      tag = $sformatf("v%0d", k);
      wa.delete();
      wd.delete();
      pulse_start_task();
      chk({tag, "_busy_start"}, 64'(busy), 64'd1);
      send_word(v.hdr, v.gappy, 1'b0);
      sum = 32'd0;
      for (int i = 0; i < int'(v.nw); i++) begin
        send_word(v.w[i], v.gappy, v.start_mid && (i == 1));
        sum = sum + v.w[i];
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (v.hdr <= 32'd16) send_word(sum ^ v.txor, v.gappy, 1'b0);
      exp_err = v.exp_err_ck;
`else
      exp_err = v.exp_err;
      if (v.imm_done) chk({tag, "_done_next_cycle"}, 64'(done), 64'd1);
`endif
      byte_valid = 1'b0;
      wait_done(tag);
      repeat (3) @(negedge clk);
      chk({tag, "_busy"},       64'(busy),       64'd0);
      chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
      chk({tag, "_error"},      64'(error),      64'(exp_err));
      chk({tag, "_word_count"}, 64'(word_count), 64'(v.exp_wc));
      chk({tag, "_nwrites"},    64'(wa.size()),  64'(v.exp_wc));
      for (int i = 0; i < wa.size() && i < int'(v.exp_wc); i++) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(wa[i]), 64'(i));
        chk($sformatf("%s_data%0d", tag, i), 64'(wd[i]), 64'(v.w[i]));
      end
      if (v.exp_wc != 0) begin
        chk({tag, "_hold_addr"},  64'(imem_addr),  64'(v.exp_wc - 5'd1));
        chk({tag, "_hold_wdata"}, 64'(imem_wdata), 64'(v.w[v.exp_wc - 5'd1]));
      end
    end

    // Bytes offered while not ready are ignored
    wa.delete();
    byte_valid = 1'b1;
    byte_data  = 8'hAB;
    repeat (6) @(negedge clk);
    chk("idle_byte_ready", 64'(byte_ready), 64'd0);
    chk("idle_word_count", 64'(word_count), 64'd2);
    chk("idle_done",       64'(done),       64'd1);
    chk("idle_nwrites",    64'(wa.size()),  64'd0);
    byte_valid = 1'b0;

    // Asynchronous reset after 6 body bytes, then a fresh single-word load
    pulse_start_task();
    send_word(32'd2, 1'b0, 1'b0);
    send_word(32'hCAFEF00D, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",       64'(busy),       64'd0);
    chk("mid_rst_done",       64'(done),       64'd0);
    chk("mid_rst_error",      64'(error),      64'd0);
    chk("mid_rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("mid_rst_word_count", 64'(word_count), 64'd0);
    chk("mid_rst_imem_addr",  64'(imem_addr),  64'd0);
    chk("mid_rst_imem_wdata", 64'(imem_wdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wa.delete();
    wd.delete();
    pulse_start_task();
    send_word(32'd1, 1'b0, 1'b0);
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
`endif
    byte_valid = 1'b0;
    wait_done("post_rst");
    repeat (2) @(negedge clk);
    chk("post_rst_nwrites",    64'(wa.size()),  64'd1);
    if (wa.size() > 0) begin
      chk("post_rst_addr", 64'(wa[0]), 64'd0);
      chk("post_rst_data", 64'(wd[0]), 64'hDEADBEEF);
    end
    chk("post_rst_word_count", 64'(word_count), 64'd1);
    chk("post_rst_error",      64'(error),      64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
